// File: rtl/pipeline_buffer_if.sv
// Handshake, control and status bundle for pipeline_buffer.
// slave: the buffer's view; master: the producer/consumer/controller side.
interface pipeline_buffer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic                  s_data_valid;
    logic                  s_data_ready;
    logic [DATA_WIDTH-1:0] s_data_data;
    logic                  m_data_valid;
    logic                  m_data_ready;
    logic [DATA_WIDTH-1:0] m_data_data;
    logic                  s_ctrl_flush;
    logic                  s_ctrl_stall;
    logic                  s_status_busy;
    logic [CW-1:0]         s_status_count;
    logic                  s_status_full;
    logic                  s_status_afull;

    modport slave (
        input  s_data_valid, s_data_data, m_data_ready, s_ctrl_flush, s_ctrl_stall,
        output s_data_ready, m_data_valid, m_data_data,
               s_status_busy, s_status_count, s_status_full, s_status_afull
    );

    modport master (
        output s_data_valid, s_data_data, m_data_ready, s_ctrl_flush, s_ctrl_stall,
        input  s_data_ready, m_data_valid, m_data_data,
               s_status_busy, s_status_count, s_status_full, s_status_afull
    );
endinterface

// File: rtl/pipeline_buffer.sv
// Elastic pipeline stage: circular buffer of DEPTH entries with valid/ready
// on both sides, flush/stall control and occupancy status.
// The interface instance must be built with the same DATA_WIDTH and DEPTH.
module pipeline_buffer #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned READY_PASS   = 1,
    parameter int unsigned AFULL_THRESH = DEPTH - 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pipeline_buffer_if.slave   bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    // A threshold of 0 would hold afull high while empty; clamp to 1.
    localparam int unsigned AT = (AFULL_THRESH < 1) ? 1 : AFULL_THRESH;

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AT);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic w_block;
    logic w_full;
    logic w_nonempty;
    logic w_s_ready;
    logic w_m_valid;
    logic w_push;
    logic w_pop;

    assign w_block    = rst_i | bus.s_ctrl_flush | bus.s_ctrl_stall;
    assign w_full     = (r_count == FULL_CNT);
    assign w_nonempty = (r_count != '0);

    // READY_PASS=0 keeps m_data_ready out of the s_data_ready cone entirely.
    assign w_s_ready = ~w_block &
                       ((READY_PASS != 0) ? (~w_full | bus.m_data_ready) : ~w_full);
    assign w_m_valid = w_nonempty & ~w_block;

    assign w_push = bus.s_data_valid & w_s_ready;
    assign w_pop  = w_m_valid & bus.m_data_ready;

    assign bus.s_data_ready   = w_s_ready;
    assign bus.m_data_valid   = w_m_valid;
    assign bus.m_data_data    = w_nonempty ? r_mem[r_rd_ptr] : '0;
    assign bus.s_status_busy  = w_nonempty;
    assign bus.s_status_count = r_count;
    assign bus.s_status_full  = w_full;
    assign bus.s_status_afull = (r_count >= AF_CNT);

    // Storage write; push already excludes reset/flush/stall and invalid input.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.s_data_data;
        end
    end

    // Pointer and occupancy update: reset/flush clear, stall holds.
    always_ff @(posedge clk_i) begin
        if (rst_i || bus.s_ctrl_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (!bus.s_ctrl_stall) begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pipeline_buffer.sv
// Directed bench for pipeline_buffer: three instances (DEPTH=4 pass-through,
// DEPTH=3 pass-through, DEPTH=3 registered ready) sharing clock and reset.
module tb_pipeline_buffer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pipeline_buffer_if #(.DATA_WIDTH(32), .DEPTH(4)) b4 ();
    pipeline_buffer_if #(.DATA_WIDTH(32), .DEPTH(3)) b1 ();
    pipeline_buffer_if #(.DATA_WIDTH(32), .DEPTH(3)) b0 ();

    pipeline_buffer #(.DATA_WIDTH(32), .DEPTH(4), .READY_PASS(1), .AFULL_THRESH(3)) u_d4 (
        .clk_i(clk), .rst_i(rst), .bus(b4.slave));
    pipeline_buffer #(.DATA_WIDTH(32), .DEPTH(3), .READY_PASS(1), .AFULL_THRESH(2)) u_p1 (
        .clk_i(clk), .rst_i(rst), .bus(b1.slave));
    pipeline_buffer #(.DATA_WIDTH(32), .DEPTH(3), .READY_PASS(0), .AFULL_THRESH(2)) u_p0 (
        .clk_i(clk), .rst_i(rst), .bus(b0.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (b4.s_data_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready_low: got %b expected 0", b4.s_data_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (b4.m_data_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mvalid: got %b expected 0", b4.m_data_valid);
        end
        checks++;
        if (b4.m_data_data !== 32'h0) begin
            errors++; $display("FAIL reset_mdata: got %h expected 0", b4.m_data_data);
        end
        checks++;
        if (b4.s_status_count !== 3'd0 || b1.s_status_count !== 2'd0 || b0.s_status_count !== 2'd0) begin
            errors++; $display("FAIL reset_count: got %0d/%0d/%0d expected 0/0/0",
                               b4.s_status_count, b1.s_status_count, b0.s_status_count);
        end
        checks++;
        if (b4.s_data_ready !== 1'b1 || b1.s_data_ready !== 1'b1 || b0.s_data_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready_high: got %b%b%b expected 111",
                               b4.s_data_ready, b1.s_data_ready, b0.s_data_ready);
        end
        checks++;
        if ({b4.s_status_busy, b4.s_status_full, b4.s_status_afull} !== 3'b000) begin
            errors++; $display("FAIL reset_status: got %b%b%b expected 000",
                               b4.s_status_busy, b4.s_status_full, b4.s_status_afull);
        end
        step();
    endtask

    task automatic test_fill_drain();
        b4.m_data_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b4.s_data_valid = 1'b1;
            b4.s_data_data  = 32'hA1 + 32'(i);
            #1;
            checks++;
            if (b4.s_data_ready !== (i < 4)) begin
                errors++; $display("FAIL fill_ready[%0d]: got %b expected %b", i, b4.s_data_ready, (i < 4));
            end
            checks++;
            if (b4.s_status_afull !== (i >= 3) || b4.s_status_full !== (i == 4)) begin
                errors++; $display("FAIL fill_flags[%0d]: got afull=%b full=%b expected afull=%b full=%b",
                                   i, b4.s_status_afull, b4.s_status_full, (i >= 3), (i == 4));
            end
            step();
        end
        b4.s_data_valid = 1'b0;
        b4.s_data_data  = 32'hxxxx_xxxx;
        checks++;
        if (b4.s_status_count !== 3'd4) begin
            errors++; $display("FAIL fill_count: got %0d expected 4", b4.s_status_count);
        end
        b4.m_data_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (b4.m_data_valid !== 1'b1 || b4.m_data_data !== 32'hA1 + 32'(i)) begin
                errors++; $display("FAIL drain_data[%0d]: got v=%b %h expected v=1 %h",
                                   i, b4.m_data_valid, b4.m_data_data, 32'hA1 + 32'(i));
            end
            checks++;
            if (b4.s_status_count !== 3'(4 - i)) begin
                errors++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, b4.s_status_count, 4 - i);
            end
            step();
        end
        b4.m_data_ready = 1'b0;
        #1;
        checks++;
        if (b4.s_status_count !== 3'd0 || b4.m_data_valid !== 1'b0 || b4.m_data_data !== 32'h0) begin
            errors++; $display("FAIL drain_empty: got cnt=%0d v=%b d=%h expected 0 0 0",
                               b4.s_status_count, b4.m_data_valid, b4.m_data_data);
        end
        step();
    endtask

    task automatic test_pass_full();
        b1.m_data_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b1.s_data_valid = 1'b1;
            b1.s_data_data  = 32'hB0 + 32'(i);
            step();
        end
        b1.m_data_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            b1.s_data_data = 32'hB3 + 32'(k);
            #1;
            checks++;
            if (b1.s_data_ready !== 1'b1 || b1.s_status_count !== 2'd3) begin
                errors++; $display("FAIL pass_ready_count[%0d]: got rdy=%b cnt=%0d expected 1 3",
                                   k, b1.s_data_ready, b1.s_status_count);
            end
            checks++;
            if (b1.m_data_valid !== 1'b1 || b1.m_data_data !== 32'hB0 + 32'(k)) begin
                errors++; $display("FAIL pass_data[%0d]: got v=%b %h expected v=1 %h",
                                   k, b1.m_data_valid, b1.m_data_data, 32'hB0 + 32'(k));
            end
            step();
        end
        b1.s_data_valid = 1'b0;
        for (int k = 10; k < 13; k++) begin
            #1;
            checks++;
            if (b1.m_data_data !== 32'hB0 + 32'(k) || b1.s_status_count !== 2'(13 - k)) begin
                errors++; $display("FAIL pass_tail[%0d]: got %h cnt=%0d expected %h cnt=%0d",
                                   k, b1.m_data_data, b1.s_status_count, 32'hB0 + 32'(k), 13 - k);
            end
            step();
        end
        b1.m_data_ready = 1'b0;
    endtask

    task automatic test_no_pass();
        b0.m_data_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b0.s_data_valid = 1'b1;
            b0.s_data_data  = 32'hC0 + 32'(i);
            step();
        end
        b0.s_data_data = 32'hC3;
        #1;
        checks++;
        if (b0.s_data_ready !== 1'b0) begin
            errors++; $display("FAIL nopass_full_ready: got %b expected 0", b0.s_data_ready);
        end
        b0.m_data_ready = 1'b1;
        #1;
        checks++;
        if (b0.s_data_ready !== 1'b0) begin
            errors++; $display("FAIL nopass_toggle_ready: got %b expected 0", b0.s_data_ready);
        end
        for (int k = 0; k < 10; k++) begin
            b0.s_data_data = 32'hC3 + 32'((k == 0) ? 0 : k - 1);
            #1;
            checks++;
            if (b0.s_data_ready !== (k != 0) || b0.s_status_count !== ((k == 0) ? 2'd3 : 2'd2)) begin
                errors++; $display("FAIL nopass_ready_count[%0d]: got rdy=%b cnt=%0d expected %b %0d",
                                   k, b0.s_data_ready, b0.s_status_count, (k != 0), (k == 0) ? 3 : 2);
            end
            checks++;
            if (b0.m_data_data !== 32'hC0 + 32'(k)) begin
                errors++; $display("FAIL nopass_data[%0d]: got %h expected %h",
                                   k, b0.m_data_data, 32'hC0 + 32'(k));
            end
            step();
        end
        b0.s_data_valid = 1'b0;
        for (int k = 10; k < 12; k++) begin
            #1;
            checks++;
            if (b0.m_data_data !== 32'hC0 + 32'(k)) begin
                errors++; $display("FAIL nopass_tail[%0d]: got %h expected %h",
                                   k, b0.m_data_data, 32'hC0 + 32'(k));
            end
            step();
        end
        #1;
        checks++;
        if (b0.s_status_count !== 2'd0) begin
            errors++; $display("FAIL nopass_empty: got %0d expected 0", b0.s_status_count);
        end
        b0.m_data_ready = 1'b0;
        step();
    endtask

    task automatic test_stall();
        b4.m_data_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            b4.s_data_valid = 1'b1;
            b4.s_data_data  = 32'hD0 + 32'(i);
            step();
        end
        b4.s_ctrl_stall = 1'b1;
        b4.m_data_ready = 1'b1;
        b4.s_data_data  = 32'hD2;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (b4.s_data_ready !== 1'b0 || b4.m_data_valid !== 1'b0) begin
                errors++; $display("FAIL stall_handshake[%0d]: got rdy=%b v=%b expected 0 0",
                                   k, b4.s_data_ready, b4.m_data_valid);
            end
            checks++;
            if (b4.s_status_count !== 3'd2 || b4.m_data_data !== 32'hD0 || b4.s_status_busy !== 1'b1) begin
                errors++; $display("FAIL stall_hold[%0d]: got cnt=%0d d=%h busy=%b expected 2 d0 1",
                                   k, b4.s_status_count, b4.m_data_data, b4.s_status_busy);
            end
            step();
        end
        b4.s_ctrl_stall = 1'b0;
        b4.s_data_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (b4.m_data_valid !== 1'b1 || b4.m_data_data !== 32'hD0 + 32'(i)) begin
                errors++; $display("FAIL stall_resume[%0d]: got v=%b %h expected v=1 %h",
                                   i, b4.m_data_valid, b4.m_data_data, 32'hD0 + 32'(i));
            end
            step();
        end
        b4.m_data_ready = 1'b0;
    endtask

    task automatic test_flush();
        b4.m_data_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b4.s_data_valid = 1'b1;
            b4.s_data_data  = 32'hE0 + 32'(i);
            step();
        end
        b4.s_ctrl_flush = 1'b1;
        b4.s_ctrl_stall = 1'b1;
        b4.s_data_data  = 32'hEE;
        #1;
        checks++;
        if (b4.s_data_ready !== 1'b0 || b4.m_data_valid !== 1'b0) begin
            errors++; $display("FAIL flush_handshake: got rdy=%b v=%b expected 0 0",
                               b4.s_data_ready, b4.m_data_valid);
        end
        step();
        b4.s_ctrl_flush = 1'b0;
        b4.s_ctrl_stall = 1'b0;
        b4.s_data_data  = 32'hF0;
        #1;
        checks++;
        if (b4.s_status_count !== 3'd0 || b4.m_data_valid !== 1'b0 || b4.s_data_ready !== 1'b1) begin
            errors++; $display("FAIL flush_empty: got cnt=%0d v=%b rdy=%b expected 0 0 1",
                               b4.s_status_count, b4.m_data_valid, b4.s_data_ready);
        end
        step();
        b4.s_data_valid = 1'b0;
        #1;
        checks++;
        if (b4.m_data_valid !== 1'b1 || b4.m_data_data !== 32'hF0 || b4.s_status_count !== 3'd1) begin
            errors++; $display("FAIL flush_next_push: got v=%b %h cnt=%0d expected 1 f0 1",
                               b4.m_data_valid, b4.m_data_data, b4.s_status_count);
        end
        b4.m_data_ready = 1'b1;
        step();
        b4.m_data_ready = 1'b0;
        #1;
        checks++;
        if (b4.s_status_count !== 3'd0) begin
            errors++; $display("FAIL flush_final: got %0d expected 0", b4.s_status_count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        b4.s_data_valid = 1'b0; b4.s_data_data = '0; b4.m_data_ready = 1'b0;
        b4.s_ctrl_flush = 1'b0; b4.s_ctrl_stall = 1'b0;
        b1.s_data_valid = 1'b0; b1.s_data_data = '0; b1.m_data_ready = 1'b0;
        b1.s_ctrl_flush = 1'b0; b1.s_ctrl_stall = 1'b0;
        b0.s_data_valid = 1'b0; b0.s_data_data = '0; b0.m_data_ready = 1'b0;
        b0.s_ctrl_flush = 1'b0; b0.s_ctrl_stall = 1'b0;

        test_reset();
        test_fill_drain();
        test_pass_full();
        test_no_pass();
        test_stall();
        test_flush();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
